sobel_window_gen: RTL and testbench

//  Feeds the Sobel core. Takes a raster-order 8-bit pixel stream and buffers two

---
 rtl/sobel_window_gen.sv | 132 +++++++++++++
 tb/tb_sobel_window_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Purpose: turns a raster 8-bit pixel stream into registered 3x3 interior windows using two line buffers.
// Latency: one cycle from the accept of the window's bottom-right pixel to out_valid.
// Backpressure: in_ready = !out_valid | out_ready; a stalled window and its coordinates hold until taken.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    localparam int XW        = $clog2(IMG_WIDTH),
    localparam int YW        = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             frame_done
);

    logic [XW-1:0]    x;
    logic [XW-1:0]    x_eff;
    logic [YW-1:0]    y;
    logic [YW-1:0]    y_eff;
    logic             accept;
    logic             qualify;
    logic             last_col;
    logic             last_row;

    // line0 holds row y-1, line1 holds row y-2 (relative to the row being received)
    logic [PIX_W-1:0] line0 [IMG_WIDTH];
    logic [PIX_W-1:0] line1 [IMG_WIDTH];

    // window registers, index 0..8 maps to p0..p8
    logic [PIX_W-1:0] win [9];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // a start-of-frame pixel is always treated as column 0 of row 0
    assign x_eff    = in_sof ? '0 : x;
    assign y_eff    = in_sof ? '0 : y;
    assign qualify  = (x_eff >= XW'(2)) && (y_eff >= YW'(2));
    assign last_col = (x_eff == XW'(IMG_WIDTH - 1));
    assign last_row = (y_eff == YW'(IMG_HEIGHT - 1));

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

    // raster position counters and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (last_col) begin
                    x <= '0;
                    if (last_row) begin
                        y          <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        y <= y_eff + YW'(1);
                    end
                end else begin
                    x <= x_eff + XW'(1);
                    y <= y_eff;
                end
            end
        end
    end

    // shift the window left and load the new right column; track output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (accept) begin
            win[0]    <= win[1];
            win[1]    <= win[2];
            win[2]    <= line1[x_eff];
            win[3]    <= win[4];
            win[4]    <= win[5];
            win[5]    <= line0[x_eff];
            win[6]    <= win[7];
            win[7]    <= win[8];
            win[8]    <= in_pixel;
            out_valid <= qualify;
            // coordinates only move for emitted windows, so no wrap on edge pixels
            if (qualify) begin
                out_x <= x_eff - XW'(1);
                out_y <= y_eff - YW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // age the column through the line buffers; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            line1[x_eff] <= line0[x_eff];
            line0[x_eff] <= in_pixel;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int WV = 9 * PW + XW + YW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          frame_done;
    logic [WV-1:0] win_now;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done)
    );

    assign win_now = {p0, p1, p2, p3, p4, p5, p6, p7, p8, out_x, out_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [PW-1:0] img [H][W];
    logic [WV-1:0] exp_q [$];
    logic [WV-1:0] got_q [$];
    logic [WV-1:0] s1_q  [$];
    logic [WV-1:0] held;
    int            idx = 0;
    bit            exp_ov = 0;
    bit            exp_fd = 0;
    bit            stalled_prev = 0;
    int            n_fd = 0;
    int            n_stall = 0;

    // window expected from the model image, pixel (cx,cy) is the bottom-right
    function automatic logic [WV-1:0] model_win(input int cx, input int cy);
        logic [71:0] px = '0;
        for (int r = cy - 2; r <= cy; r++)
            for (int c = cx - 2; c <= cx; c++)
                px = {px[63:0], img[r][c]};
        return {px, XW'(cx - 1), YW'(cy - 1)};
    endfunction

    // window for the directed pattern pixel(x,y)=10*y+x, centred on (ox,oy)
    function automatic logic [WV-1:0] pat_win(input int ox, input int oy);
        logic [71:0] px = '0;
        for (int r = oy - 1; r <= oy + 1; r++)
            for (int c = ox - 1; c <= ox + 1; c++)
                px = {px[63:0], PW'(10 * r + c)};
        return {px, XW'(ox), YW'(oy)};
    endfunction

    // monitor: output handoff first (current window), then the accept that lands next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            idx          = 0;
            exp_ov       = 0;
            exp_fd       = 0;
            stalled_prev = 0;
        end else begin
            check("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
            check("out_valid", 128'(out_valid), 128'(exp_ov));
            if (stalled_prev && out_valid)
                check("hold", 128'(win_now), 128'(held));
            if (out_valid && !out_ready) n_stall++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("extra_window", 128'(win_now), 128'(0));
                else
                    check("window", 128'(win_now), 128'(exp_q.pop_front()));
                got_q.push_back(win_now);
                exp_ov = 0;
            end
            stalled_prev = out_valid && !out_ready;
            held         = win_now;
            if (frame_done || exp_fd)
                check("frame_done", 128'(frame_done), 128'(exp_fd));
            if (frame_done) n_fd++;
            exp_fd = 0;
            if (in_valid && in_ready) begin
                int px, py;
                if (in_sof) idx = 0;
                px = idx % W;
                py = idx / W;
                img[py][px] = in_pixel;
                if (px >= 2 && py >= 2) begin
                    exp_q.push_back(model_win(px, py));
                    exp_ov = 1;
                end
                if (idx == W * H - 1) begin
                    exp_fd = 1;
                    idx    = 0;
                end else begin
                    idx++;
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode   = 0;
    int stall_left = 0;
    bit stall_done = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (!stall_done && out_valid && out_x == 3'd2 && out_y == 2'd1) begin
                    out_ready  = 1'b0;
                    stall_left = 4;
                    stall_done = 1;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- input driver ----------------
    bit gaps = 0;

    task automatic send(input logic [PW-1:0] pix, input logic sof);
        bit acc;
        int n;
        if (gaps) begin
            int g = int'($urandom_range(0, 2));
            repeat (g) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        n        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            $display("FAIL accept_timeout got=0 exp=1");
            $fatal(1, "input never accepted");
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic pattern_frame(input int npix, input logic sof_first);
        for (int i = 0; i < npix; i++)
            send(PW'(10 * (i / W) + (i % W)), sof_first && (i == 0));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic start_scenario();
        got_q.delete();
        n_fd    = 0;
        n_stall = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ov"}, 128'(out_valid), 128'(0));
        check({tag, "_fd"}, 128'(frame_done), 128'(0));
        check({tag, "_win"}, 128'(win_now), 128'(0));
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // full frame with free-flowing output; also covers the row-wrap windows
        start_scenario();
        pattern_frame(W * H, 1'b0);
        drain();
        check("s1_count", 128'(got_q.size()), 128'(6));
        check("s1_fd_count", 128'(n_fd), 128'(1));
        if (got_q.size() == 6) begin
            check("s1_first", 128'(got_q[0]), 128'(pat_win(1, 1)));
            check("s3_after_4_2", 128'(got_q[2]), 128'(pat_win(3, 1)));
            check("s3_after_2_3", 128'(got_q[3]), 128'(pat_win(1, 2)));
            check("s1_last", 128'(got_q[5]), 128'(pat_win(3, 2)));
        end
        s1_q = got_q;

        // 5-cycle stall on the second window
        start_scenario();
        rdy_mode = 2;
        pattern_frame(W * H, 1'b1);
        drain();
        rdy_mode = 0;
        check("s2_stalled", 128'(stall_done), 128'(1));
        check("s2_stall_cycles", 128'(n_stall), 128'(5));
        check("s2_count", 128'(got_q.size()), 128'(6));
        if (got_q.size() == 6)
            check("s2_win2", 128'(got_q[1]), 128'(pat_win(2, 1)));

        // frame aborted after 7 pixels, restarted by in_sof
        start_scenario();
        pattern_frame(7, 1'b1);
        pattern_frame(W * H, 1'b1);
        drain();
        check("s5_count", 128'(got_q.size()), 128'(6));
        check("s5_fd_count", 128'(n_fd), 128'(1));
        if (got_q.size() == 6)
            check("s5_first", 128'(got_q[0]), 128'(pat_win(1, 1)));

        // reset mid-frame while a window is pending
        start_scenario();
        pattern_frame(13, 1'b1);
        check("s6_pre_ov", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        #1 check_reset_vals("s6_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_scenario();
        pattern_frame(W * H, 1'b0);
        drain();
        check("s6_count", 128'(got_q.size()), 128'(s1_q.size()));
        if (got_q.size() == s1_q.size())
            for (int i = 0; i < got_q.size(); i++)
                check("s6_repeat", 128'(got_q[i]), 128'(s1_q[i]));
        check("s6_fd_count", 128'(n_fd), 128'(1));

        // random pixels with random input gaps and output back-pressure, 3 frames
        start_scenario();
        rdy_mode = 1;
        gaps     = 1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < W * H; i++)
                send(PW'($urandom), i == 0);
        gaps = 0;
        drain();
        rdy_mode = 0;
        check("s4_count", 128'(got_q.size()), 128'(18));
        check("s4_fd_count", 128'(n_fd), 128'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
